// File: rtl/alu_op_arbiter_if.sv
// Bundle of request, ALU and response signals shared by the arbiter and its
// surroundings. The slave side is the arbiter; the master side holds the
// requesters, the combinational ALU and the response consumer.
interface alu_op_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [3:0]  req0_a;
  logic [3:0]  req0_b;
  logic        req0_cin;
  logic [2:0]  req0_op;

  logic        req1_valid;
  logic        req1_ready;
  logic [3:0]  req1_a;
  logic [3:0]  req1_b;
  logic        req1_cin;
  logic [2:0]  req1_op;

  logic [3:0]  alu_a;
  logic [3:0]  alu_b;
  logic        alu_cin;
  logic [2:0]  alu_op;
  logic [11:0] alu_bcd;
  logic        alu_cout;
  logic        alu_ovf;

  logic        resp_valid;
  logic        resp_ready;
  logic        resp_id;
  logic [11:0] resp_bcd;
  logic        resp_cout;
  logic        resp_ovf;
  logic        resp_err;

  modport master (
    output req0_valid, req0_a, req0_b, req0_cin, req0_op,
    output req1_valid, req1_a, req1_b, req1_cin, req1_op,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_cin, alu_op,
    output alu_bcd, alu_cout, alu_ovf,
    input  resp_valid, resp_id, resp_bcd, resp_cout, resp_ovf, resp_err,
    output resp_ready
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cin, req0_op,
    input  req1_valid, req1_a, req1_b, req1_cin, req1_op,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_cin, alu_op,
    input  alu_bcd, alu_cout, alu_ovf,
    output resp_valid, resp_id, resp_bcd, resp_cout, resp_ovf, resp_err,
    input  resp_ready
  );
endinterface

// File: rtl/alu_op_arbiter.sv
// Round-robin arbiter and sequencer in front of the shared 4-bit BCD ALU.
// One operation is in flight at a time: accept in IDLE, let the ALU settle
// in EXEC, then present the captured result in RESP until it is consumed.
module alu_op_arbiter #(
  parameter int SETTLE_CYCLES = 1
) (
  input logic             clk,
  input logic             rst_n,
  alu_op_arbiter_if.slave arb_bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_count;
  logic        r_last_grant;

  logic [3:0]  r_alu_a;
  logic [3:0]  r_alu_b;
  logic        r_alu_cin;
  logic [2:0]  r_alu_op;

  logic        r_resp_id;
  logic [11:0] r_resp_bcd;
  logic        r_resp_cout;
  logic        r_resp_ovf;
  logic        r_resp_err;

  logic        w_any_valid;
  logic        w_grant;
  logic [3:0]  w_sel_a;
  logic [3:0]  w_sel_b;
  logic        w_sel_cin;
  logic [2:0]  w_sel_op;
  logic        w_illegal;
  logic        w_accept;
  logic        w_capture;
  logic        w_req0_ready;
  logic        w_req1_ready;
  logic        w_resp_valid;

  // Pick the winner (alternate on a tie) and steer its payload forward
  always_comb begin
    w_any_valid = arb_bus.req0_valid | arb_bus.req1_valid;
    if (arb_bus.req0_valid && arb_bus.req1_valid) begin
      w_grant = ~r_last_grant;
    end else begin
      w_grant = arb_bus.req1_valid;
    end
    w_sel_a   = w_grant ? arb_bus.req1_a   : arb_bus.req0_a;
    w_sel_b   = w_grant ? arb_bus.req1_b   : arb_bus.req0_b;
    w_sel_cin = w_grant ? arb_bus.req1_cin : arb_bus.req0_cin;
    w_sel_op  = w_grant ? arb_bus.req1_op  : arb_bus.req0_op;
    w_illegal = (w_sel_op[1:0] == 2'b11);
    w_accept  = (r_state == IDLE) && w_any_valid;
    w_capture = (r_state == EXEC) && (r_count == 4'd1);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decision: illegal ops skip the ALU and answer right away
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state = w_illegal ? RESP : EXEC;
        end
      end
      EXEC: begin
        if (w_capture) begin
          w_next_state = RESP;
        end
      end
      RESP: begin
        if (arb_bus.resp_ready) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Handshake outputs decoded from state; only the winner sees ready
  always_comb begin
    w_req0_ready = w_accept && !w_grant;
    w_req1_ready = w_accept &&  w_grant;
    w_resp_valid = (r_state == RESP);
  end

  // Operand latch, settle counter, round-robin memory and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count      <= 4'd0;
      r_last_grant <= 1'b1;
      r_alu_a      <= 4'd0;
      r_alu_b      <= 4'd0;
      r_alu_cin    <= 1'b0;
      r_alu_op     <= 3'd0;
      r_resp_id    <= 1'b0;
      r_resp_bcd   <= 12'd0;
      r_resp_cout  <= 1'b0;
      r_resp_ovf   <= 1'b0;
      r_resp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_alu_a      <= w_sel_a;
        r_alu_b      <= w_sel_b;
        r_alu_cin    <= w_sel_cin;
        r_alu_op     <= w_sel_op;
        r_resp_id    <= w_grant;
        r_last_grant <= w_grant;
        if (w_illegal) begin
          r_resp_err  <= 1'b1;
          r_resp_bcd  <= 12'd0;
          r_resp_cout <= 1'b0;
          r_resp_ovf  <= 1'b0;
        end else begin
          r_count <= 4'(SETTLE_CYCLES);
        end
      end else if (r_state == EXEC) begin
        r_count <= r_count - 4'd1;
        if (w_capture) begin
          r_resp_bcd  <= arb_bus.alu_bcd;
          r_resp_cout <= arb_bus.alu_cout;
          r_resp_ovf  <= arb_bus.alu_ovf;
          r_resp_err  <= 1'b0;
        end
      end
    end
  end

  assign arb_bus.req0_ready = w_req0_ready;
  assign arb_bus.req1_ready = w_req1_ready;
  assign arb_bus.alu_a      = r_alu_a;
  assign arb_bus.alu_b      = r_alu_b;
  assign arb_bus.alu_cin    = r_alu_cin;
  assign arb_bus.alu_op     = r_alu_op;
  assign arb_bus.resp_valid = w_resp_valid;
  assign arb_bus.resp_id    = r_resp_id;
  assign arb_bus.resp_bcd   = r_resp_bcd;
  assign arb_bus.resp_cout  = r_resp_cout;
  assign arb_bus.resp_ovf   = r_resp_ovf;
  assign arb_bus.resp_err   = r_resp_err;

endmodule

// File: doc/alu_op_arbiter.md
# alu_op_arbiter

Two-port arbiter and sequencer for the shared 4-bit ALU datapath (ADD/SUB/MULT/AND/OR/XOR with BCD result). It accepts operation requests from two requesters over valid/ready handshakes, grants the ALU round-robin, and drives registered operands and opcode into the combinational ALU. After a fixed settle window it captures the ALU's BCD result and flags, then returns them on a single tagged response channel. Illegal opcodes are rejected without occupying the ALU.

## Interface
- SETTLE_CYCLES, 1, cycles the ALU inputs are held before result capture; legal range 1–15.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  requester n has an operation pending.
- req0_ready / req1_ready  out  1  requester n accepted this cycle when valid&ready.
- req0_a, req0_b / req1_a, req1_b  in  4  operands.
- req0_cin / req1_cin  in  1  carry-in.
- req0_op / req1_op  in  3  opcode: 0 ADD, 1 SUB, 2 MULT, 4 AND, 5 OR, 6 XOR; 3 and 7 illegal.
- alu_a, alu_b  out  4  registered operands to ALU.
- alu_cin  out  1  registered carry-in to ALU.
- alu_op  out  3  registered opcode to ALU.
- alu_bcd  in  12  ALU BCD result.
- alu_cout, alu_ovf  in  1  ALU carry-out, overflow.
- resp_valid  out  1  response available.
- resp_ready  in  1  response consumer ready.
- resp_id  out  1  requester that issued the operation.
- resp_bcd  out  12  captured result.
- resp_cout, resp_ovf  out  1  captured flags.
- resp_err  out  1  operation rejected (illegal opcode).

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: compute the grant. With one requester valid, grant it. With both valid, grant the requester not in last_grant. Only the granted requester's ready is high; both readys are low outside IDLE. Readys are combinational from state and valids.
- On acceptance (valid&ready in IDLE):
  - latch the granted a/b/cin/op into alu_*;
  - set resp_id and last_grant to the granted index;
  - legal op: load counter with SETTLE_CYCLES, go to EXEC;
  - illegal op: go to RESP with resp_err=1 and resp_bcd/cout/ovf=0. alu_* still update.
- EXEC: decrement the counter each cycle. On the edge where the counter is 1, capture alu_bcd/alu_cout/alu_ovf into the resp_* registers, clear resp_err, go to RESP.
- RESP: resp_valid=1. All resp_* fields are held stable until resp_valid&resp_ready, then go to IDLE.
- alu_* change only on acceptance. They hold otherwise, including through RESP and IDLE.
- The controller does not alter the result. resp_bcd equals the ALU output, e.g. MULT is 0–225 in BCD, logic ops are 0–15.
- Requesters must hold valid and their payload until accepted. The arbiter does not depend on this because acceptance is same-cycle in IDLE.

## Timing
- Reset (async assert, sync-release use): state=IDLE, counter=0, last_grant=1 (req0 wins the first tie), alu_a=alu_b=0, alu_cin=0, alu_op=0. All resp_* =0, including resp_valid=0. Readys follow IDLE rules.
- Reset mid-EXEC or mid-RESP: the in-flight operation is dropped and no response is produced.
- Legal op accepted at edge T: resp_valid rises after edge T+SETTLE_CYCLES.
- Illegal op accepted at edge T: resp_valid rises after edge T.
- With resp_ready tied high, the response handshake completes at edge T+SETTLE_CYCLES+1 and the earliest next acceptance is at edge T+SETTLE_CYCLES+2. Throughput is 1 op per SETTLE_CYCLES+2 cycles.
- resp_ready low stalls in RESP indefinitely. No new request is accepted during the stall.
- A request arriving during EXEC/RESP waits. A new valid does not affect the in-flight op.

## Test plan
- After reset, req0: ADD a=3 b=2 cin=0, SETTLE_CYCLES=1, resp_ready=1:
  - req0_ready=1 on the first IDLE cycle;
  - resp_valid exactly 1 cycle after acceptance;
  - resp_id=0, resp_bcd=12'h005, resp_cout=0, resp_ovf=0, resp_err=0.
- req1 MULT a=15 b=15 with SETTLE_CYCLES=3:
  - resp_valid exactly 3 cycles after acceptance;
  - resp_bcd=12'h225, resp_id=1;
  - alu_a/alu_b stay 15/15 through RESP.
- Both valid continuously, both issuing AND a=12 b=10:
  - grants alternate 0,1,0,1;
  - every resp_bcd=12'h008;
  - never two accepts without an intervening response.
- req0 op=3'd7:
  - resp_valid the cycle after acceptance;
  - resp_err=1, resp_bcd=0.
  - Then req0 XOR a=5 b=3 gives resp_bcd=12'h006 with err=0.
- resp_ready held low 5 cycles in RESP:
  - resp_* stable, both readys 0;
  - response completes on the cycle ready rises;
  - a pending req1 is accepted the next cycle.
- rst_n pulsed low during EXEC:
  - all outputs return to reset values immediately;
  - no response is produced for the dropped op;
  - a post-reset tie is granted to req0.
